// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive path.
// Parity encoding matches uart_tx; FSM state enums for uart_rx/uart_rx_line.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    LINE_FILL,
    LINE_DISCARD,
    LINE_DRAIN
  } line_state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 2-flop synchronizer + bit FSM for one async serial character.
// Ports: clk, rst_n (sync, active-low), uart_in; data/valid, frame_err, parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_in,
  output logic [BITS_N-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_N + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_N - 1);
  localparam bit HAS_PAR = PARITY_TYPE != 0;
  localparam bit ODD = PARITY_TYPE == int'(PARITY_ODD);

  rx_state_t         state;
  logic              sync1;
  logic              rx;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [BITS_N-1:0] shreg;
  logic              par_acc;
  logic              par_bad;
  logic              tick;

  assign tick = cnt == FULL_M1;
  assign data = shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      rx         <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync1      <= uart_in;
      rx         <= sync1;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      cnt        <= cnt + 1'b1;
      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            // odd parity seeds the running XOR with 1
            par_acc <= ODD;
            par_bad <= 1'b0;
            state   <= rx ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (tick) begin
            cnt     <= '0;
            shreg   <= {rx, shreg[BITS_N-1:1]};
            par_acc <= par_acc ^ rx;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT)
              state <= HAS_PAR ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (tick) begin
            cnt        <= '0;
            par_bad    <= rx != par_acc;
            parity_err <= rx != par_acc;
            state      <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick) begin
            cnt       <= '0;
            valid     <= rx & ~par_bad;
            frame_err <= ~rx;
            state     <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_line.sv
// uart_rx_line: reassembles received characters into LF-terminated lines.
// Ports: clk, rst_n, uart_in; line_* valid/ready byte stream; error pulses.
module uart_rx_line
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int MAX_LINE     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_in,
  output logic [BITS_N-1:0]             line_data,
  output logic                          line_valid,
  output logic                          line_last,
  output logic [$clog2(MAX_LINE+1)-1:0] line_len,
  input  logic                          line_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow_err
);

  localparam int LW = $clog2(MAX_LINE + 1);
  localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam logic [LW-1:0] FULL = LW'(MAX_LINE);
  localparam logic [BITS_N-1:0] LF = BITS_N'(ASCII_LF);

  logic [BITS_N-1:0] mem [MAX_LINE];
  line_state_t       lstate;
  logic [LW-1:0]     wr;
  logic [LW-1:0]     rd;
  logic [BITS_N-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              rx_perr;
  logic              is_lf;
  logic              room;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .BITS_N       (BITS_N),
    .PARITY_TYPE  (PARITY_TYPE)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_in    (uart_in),
    .data       (rx_data),
    .valid      (rx_valid),
    .frame_err  (rx_ferr),
    .parity_err (rx_perr)
  );

  assign frame_err  = rx_ferr;
  assign parity_err = rx_perr;
  assign is_lf      = rx_data == LF;
  assign room       = wr != FULL;

  always_ff @(posedge clk) begin
    if (lstate == LINE_FILL && rx_valid && room)
      mem[wr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lstate       <= LINE_FILL;
      wr           <= '0;
      rd           <= '0;
      line_len     <= '0;
      line_data    <= '0;
      line_valid   <= 1'b0;
      line_last    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= 1'b0;
      unique case (lstate)
        LINE_FILL: begin
          if (rx_valid) begin
            if (!room) begin
              // an LF with no slot left still ends the bad line
              overflow_err <= 1'b1;
              wr           <= '0;
              lstate       <= is_lf ? LINE_FILL : LINE_DISCARD;
            end else if (is_lf) begin
              line_len <= wr + 1'b1;
              wr       <= '0;
              rd       <= '0;
              lstate   <= LINE_DRAIN;
            end else begin
              wr <= wr + 1'b1;
            end
          end else if (rx_ferr || rx_perr) begin
            lstate <= LINE_DISCARD;
          end
        end
        LINE_DISCARD: begin
          if (rx_valid && is_lf) begin
            wr     <= '0;
            lstate <= LINE_FILL;
          end
        end
        LINE_DRAIN: begin
          if (rx_valid) overflow_err <= 1'b1;
          // rd always points at the next byte to load
          if (!line_valid) begin
            line_valid <= 1'b1;
            line_data  <= mem[AW'(0)];
            line_last  <= line_len == LW'(1);
            rd         <= LW'(1);
          end else if (line_ready) begin
            if (line_last) begin
              line_valid <= 1'b0;
              line_last  <= 1'b0;
              rd         <= '0;
              wr         <= '0;
              lstate     <= LINE_FILL;
            end else begin
              line_data <= mem[rd[AW-1:0]];
              line_last <= rd == line_len - 1'b1;
              rd        <= rd + 1'b1;
            end
          end
        end
        default: lstate <= LINE_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_line.sv
// tb_uart_rx_line: directed test of uart_rx_line (no parity and even parity).
// Two instances: dut (PARITY 0) and dut_p (PARITY 2), CLKS_PER_BIT = 16.
module tb_uart_rx_line;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m, uart_m, ready_m;
  logic [7:0] data_m;
  logic       valid_m, last_m, fe_m, pe_m, ov_m;
  logic [5:0] len_m;

  logic       rst_p, uart_p, ready_p;
  logic [7:0] data_p;
  logic       valid_p, last_p, fe_p, pe_p, ov_p;
  logic [5:0] len_p;

  uart_rx_line #(
    .CLKS_PER_BIT (CPB), .BITS_N (8),
    .PARITY_TYPE (0), .MAX_LINE (32)
  ) dut (
    .clk (clk), .rst_n (rst_m), .uart_in (uart_m),
    .line_data (data_m), .line_valid (valid_m),
    .line_last (last_m), .line_len (len_m),
    .line_ready (ready_m), .frame_err (fe_m),
    .parity_err (pe_m), .overflow_err (ov_m)
  );

  uart_rx_line #(
    .CLKS_PER_BIT (CPB), .BITS_N (8),
    .PARITY_TYPE (2), .MAX_LINE (32)
  ) dut_p (
    .clk (clk), .rst_n (rst_p), .uart_in (uart_p),
    .line_data (data_p), .line_valid (valid_p),
    .line_last (last_p), .line_len (len_p),
    .line_ready (ready_p), .frame_err (fe_p),
    .parity_err (pe_p), .overflow_err (ov_p)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] bq[$];
  logic       lq[$];
  logic [5:0] blen;
  int fe_n, pe_n, ov_n;
  int p_beats, p_pe, p_fe, p_ov;
  logic [5:0] p_len;

  always @(negedge clk) begin
    if (valid_m && ready_m) begin
      bq.push_back(data_m);
      lq.push_back(last_m);
      blen = len_m;
    end
    if (fe_m) fe_n++;
    if (pe_m) pe_n++;
    if (ov_m) ov_n++;
    if (valid_p && ready_p) begin
      p_beats++;
      p_len = len_p;
    end
    if (fe_p) p_fe++;
    if (pe_p) p_pe++;
    if (ov_p) p_ov++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bq.delete();
    lq.delete();
    blen = '0;
    fe_n = 0;
    pe_n = 0;
    ov_n = 0;
  endtask

  task automatic drive(input bit p, input logic v);
    if (p) uart_p = v;
    else uart_m = v;
    tick(CPB);
  endtask

  // even parity bit is ^b; pbad flips it
  task automatic send_byte(input bit p, input logic [7:0] b,
                           input logic stop, input logic pbad);
    drive(p, 1'b0);
    for (int i = 0; i < 8; i++) drive(p, b[i]);
    if (p) drive(p, (^b) ^ pbad);
    drive(p, stop);
    if (!stop) begin
      for (int i = 0; i < 12; i++) drive(p, 1'b1);
    end
  endtask

  task automatic send_str(input bit p, input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(p, s[i], 1'b1, 1'b0);
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 400 && bq.size() < n; i++) tick(1);
    tick(10);
    check(tag, bq.size(), n);
  endtask

  function automatic int nbad(input string s);
    int n;
    n = 0;
    if (bq.size() != s.len()) return 999;
    foreach (bq[i]) if (bq[i] !== s[i]) n++;
    return n;
  endfunction

  function automatic int nlast();
    int n;
    n = 0;
    foreach (lq[i]) if (lq[i]) n++;
    return n;
  endfunction

  initial begin
    rst_m = 1'b0; uart_m = 1'b1; ready_m = 1'b1;
    rst_p = 1'b0; uart_p = 1'b1; ready_p = 1'b1;
    p_beats = 0; p_pe = 0; p_fe = 0; p_ov = 0; p_len = '0;
    clr();
    tick(5);
    check("rst_flags",
          {valid_m, last_m, fe_m, pe_m, ov_m}, 0);
    check("rst_data", data_m, 0);
    check("rst_len", len_m, 0);
    rst_m = 1'b1;
    rst_p = 1'b1;
    tick(5);

    // line 1: 24-byte JSON, consumer always ready
    clr();
    send_str(0, "{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
    wait_beats("l1_beats", 24);
    check("l1_first", bq[0], 8'h7B);
    check("l1_lastb", bq[23], 8'h0A);
    check("l1_lastf", lq[23], 1);
    check("l1_nlast", nlast(), 1);
    check("l1_len", blen, 24);
    check("l1_data", nbad("{\"T\":1,\"L\":0.5,\"R\":0.5}\n"), 0);
    check("l1_errs", fe_n + pe_n + ov_n, 0);
    check("l1_idle", valid_m, 0);

    // consumer stalled: second line lost byte by byte
    clr();
    ready_m = 1'b0;
    send_str(0, "hi\n");
    for (int i = 0; i < 100 && !valid_m; i++) tick(1);
    check("st_valid", valid_m, 1);
    check("st_data", data_m, 8'h68);
    check("st_len", len_m, 3);
    check("st_last", last_m, 0);
    send_str(0, "abcdef\n");
    tick(20);
    check("st_ovf", ov_n, 7);
    check("st_hold", data_m, 8'h68);
    ready_m = 1'b1;
    wait_beats("st_beats", 3);
    check("st_content", nbad("hi\n"), 0);
    check("st_lastf", lq[2], 1);
    check("st_nlast", nlast(), 1);

    // framing error on byte 3 kills that line
    clr();
    send_byte(0, 8'h61, 1'b1, 1'b0);
    send_byte(0, 8'h62, 1'b1, 1'b0);
    send_byte(0, 8'h63, 1'b0, 1'b0);
    send_byte(0, 8'h64, 1'b1, 1'b0);
    send_byte(0, 8'h0A, 1'b1, 1'b0);
    tick(30);
    check("fe_pulse", fe_n, 1);
    check("fe_drop", bq.size(), 0);
    send_str(0, "{}\n");
    wait_beats("fe_beats", 3);
    check("fe_content", nbad("{}\n"), 0);
    check("fe_len", blen, 3);
    check("fe_ovf", ov_n + pe_n, 0);

    // oversize line: one overflow pulse, nothing out
    clr();
    for (int i = 0; i < 40; i++)
      send_byte(0, 8'h78, 1'b1, 1'b0);
    send_byte(0, 8'h0A, 1'b1, 1'b0);
    tick(40);
    check("ov_pulse", ov_n, 1);
    check("ov_drop", bq.size(), 0);
    send_str(0, "ok:1\n");
    wait_beats("ov_beats", 5);
    check("ov_content", nbad("ok:1\n"), 0);
    check("ov_len", blen, 5);
    check("ov_lastf", lq[4], 1);

    // 4-cycle glitch is ignored
    clr();
    uart_m = 1'b0;
    tick(4);
    uart_m = 1'b1;
    tick(64);
    check("gl_beats", bq.size(), 0);
    check("gl_errs", fe_n + pe_n + ov_n, 0);
    check("gl_state", 32'(dut.u_rx.state), 32'(RX_IDLE));

    // even parity instance: bad parity, then reset mid-line
    send_byte(1, 8'h31, 1'b1, 1'b1);
    tick(20);
    check("pe_pulse", p_pe, 1);
    check("pe_fe", p_fe, 0);
    check("pe_drop", p_beats, 0);
    send_byte(1, 8'h0A, 1'b1, 1'b0);
    send_byte(1, 8'h0A, 1'b1, 1'b0);
    tick(20);
    check("pe_beats", p_beats, 1);
    check("pe_len", len_p, 1);
    send_byte(1, 8'h61, 1'b1, 1'b0);
    send_byte(1, 8'h62, 1'b1, 1'b0);
    uart_p = 1'b0;
    tick(40);
    rst_p = 1'b0;
    tick(1);
    check("rs_flags",
          {valid_p, last_p, fe_p, pe_p, ov_p}, 0);
    check("rs_data", data_p, 0);
    check("rs_len", len_p, 0);
    uart_p = 1'b1;
    tick(2);
    rst_p = 1'b1;
    tick(32);
    send_byte(1, 8'h0A, 1'b1, 1'b0);
    tick(30);
    check("rs_beats", p_beats, 2);
    check("rs_plen", p_len, 1);
    check("rs_errs", p_pe + p_fe + p_ov, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
